// File: rtl/text_cell_sequencer_if.sv
// Requester and text-area register-port signals of the cell write sequencer.
// The sequencer takes the slave view. Requesters and the text area side take the master view.
interface text_cell_sequencer_if;
  logic       i_blank;
  logic       i_r0_req,  i_r1_req;
  logic [6:0] i_r0_col,  i_r1_col;
  logic [5:0] i_r0_row,  i_r1_row;
  logic [7:0] i_r0_char, i_r1_char;
  logic [7:0] i_r0_fg,   i_r1_fg;
  logic [7:0] i_r0_bg,   i_r1_bg;
  logic       o_r0_ack,  o_r1_ack;
  logic       o_r0_err,  o_r1_err;
  logic       o_wr;
  logic       o_rd;
  logic [6:0] o_addr;
  logic [7:0] o_data;
  logic       o_busy;

  modport slave (
    input  i_blank,
    input  i_r0_req, i_r0_col, i_r0_row, i_r0_char, i_r0_fg, i_r0_bg,
    input  i_r1_req, i_r1_col, i_r1_row, i_r1_char, i_r1_fg, i_r1_bg,
    output o_r0_ack, o_r0_err, o_r1_ack, o_r1_err,
    output o_wr, o_rd, o_addr, o_data, o_busy
  );

  modport master (
    output i_blank,
    output i_r0_req, i_r0_col, i_r0_row, i_r0_char, i_r0_fg, i_r0_bg,
    output i_r1_req, i_r1_col, i_r1_row, i_r1_char, i_r1_fg, i_r1_bg,
    input  o_r0_ack, o_r0_err, o_r1_ack, o_r1_err,
    input  o_wr, o_rd, o_addr, o_data, o_busy
  );
endinterface

// File: rtl/text_cell_sequencer.sv
// Two-requester arbiter for the text area register port.
// It expands one cell write into the sequence column, row, char, FG, BG, commit.
// Every write cycle is followed by one gap cycle, so the write strobe is never high in back-to-back cycles.
module text_cell_sequencer #(
  parameter logic [6:0] COL_ADDR    = 7'h44,
  parameter logic [6:0] ROW_ADDR    = 7'h45,
  parameter logic [6:0] CHAR_ADDR   = 7'h46,
  parameter logic [6:0] FG_ADDR     = 7'h48,
  parameter logic [6:0] BG_ADDR     = 7'h49,
  parameter logic [6:0] COMMIT_ADDR = 7'h4A,
  parameter int         MAX_COL     = 79,
  parameter int         MAX_ROW     = 39,
  parameter bit         BLANK_ONLY  = 1'b0
) (
  input logic                   i_pix_clk,
  input logic                   i_rst,
  text_cell_sequencer_if.slave  bus
);

  localparam logic [6:0] MAX_COL_V = 7'(MAX_COL);
  localparam logic [5:0] MAX_ROW_V = 6'(MAX_ROW);

  typedef enum logic [3:0] {
    IDLE,
    COL_W, COL_G, ROW_W, ROW_G, CHR_W, CHR_G,
    FG_W,  FG_G,  BG_W,  BG_G,  CMT_W, CMT_G,
    DONE,
    ERR
  } state_t;

  typedef struct packed {
    logic [6:0] col;
    logic [5:0] row;
    logic [7:0] chr;
    logic [7:0] fg;
    logic [7:0] bg;
  } cell_t;

  state_t state_q, state_d;
  cell_t  cell_q, sel;
  logic   win_q;        // 1 = r1 owns the current sequence
  logic   prefer_r1_q;  // set when r0 was granted last
  logic   any_req, gnt_r1, range_bad, wr_ok;
  logic   wr, ack, err;
  logic [6:0] addr;
  logic [7:0] data;

  // Pick the winner of this IDLE cycle and its fields. They are used only when a request is present.
  always_comb begin
    any_req   = bus.i_r0_req | bus.i_r1_req;
    gnt_r1    = bus.i_r1_req & (~bus.i_r0_req | prefer_r1_q);
    sel       = gnt_r1 ? '{bus.i_r1_col, bus.i_r1_row, bus.i_r1_char, bus.i_r1_fg, bus.i_r1_bg}
                       : '{bus.i_r0_col, bus.i_r0_row, bus.i_r0_char, bus.i_r0_fg, bus.i_r0_bg};
    range_bad = (sel.col > MAX_COL_V) | (sel.row > MAX_ROW_V);
    wr_ok     = ~BLANK_ONLY | bus.i_blank;
  end

  // State register, field latch at grant, and round-robin pointer update on completion.
  always_ff @(posedge i_pix_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      cell_q      <= '0;
      win_q       <= 1'b0;
      prefer_r1_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && any_req) begin
        cell_q <= sel;
        win_q  <= gnt_r1;
      end
      if (state_q == DONE || state_q == ERR) prefer_r1_q <= ~win_q;
    end
  end

  // Next state and bus outputs. Write and gap states of a step drive the same address and data.
  always_comb begin
    state_d = state_q;
    wr      = 1'b0;
    ack     = 1'b0;
    err     = 1'b0;
    addr    = '0;
    data    = '0;
    unique case (state_q)
      IDLE:  if (any_req) state_d = range_bad ? ERR : COL_W;
      COL_W: begin addr = COL_ADDR;    data = {1'b0, cell_q.col}; wr = wr_ok; if (wr_ok) state_d = COL_G; end
      COL_G: begin addr = COL_ADDR;    data = {1'b0, cell_q.col}; state_d = ROW_W; end
      ROW_W: begin addr = ROW_ADDR;    data = {2'b0, cell_q.row}; wr = wr_ok; if (wr_ok) state_d = ROW_G; end
      ROW_G: begin addr = ROW_ADDR;    data = {2'b0, cell_q.row}; state_d = CHR_W; end
      CHR_W: begin addr = CHAR_ADDR;   data = cell_q.chr;         wr = wr_ok; if (wr_ok) state_d = CHR_G; end
      CHR_G: begin addr = CHAR_ADDR;   data = cell_q.chr;         state_d = FG_W; end
      FG_W:  begin addr = FG_ADDR;     data = cell_q.fg;          wr = wr_ok; if (wr_ok) state_d = FG_G; end
      FG_G:  begin addr = FG_ADDR;     data = cell_q.fg;          state_d = BG_W; end
      BG_W:  begin addr = BG_ADDR;     data = cell_q.bg;          wr = wr_ok; if (wr_ok) state_d = BG_G; end
      BG_G:  begin addr = BG_ADDR;     data = cell_q.bg;          state_d = CMT_W; end
      CMT_W: begin addr = COMMIT_ADDR; wr = wr_ok; if (wr_ok) state_d = CMT_G; end
      CMT_G: begin addr = COMMIT_ADDR; state_d = DONE; end
      DONE:  begin ack = 1'b1; state_d = IDLE; end
      ERR:   begin ack = 1'b1; err = 1'b1; state_d = IDLE; end
      default: state_d = IDLE;
    endcase
  end

  assign bus.o_wr     = wr;
  assign bus.o_rd     = 1'b0;
  assign bus.o_addr   = addr;
  assign bus.o_data   = data;
  assign bus.o_busy   = (state_q != IDLE);
  assign bus.o_r0_ack = ack & ~win_q;
  assign bus.o_r1_ack = ack &  win_q;
  assign bus.o_r0_err = err & ~win_q;
  assign bus.o_r1_err = err &  win_q;

endmodule

// File: tb/tb_text_cell_sequencer.sv
// Directed bench for text_cell_sequencer. It drives one instance in free-running mode and one in blank-only mode.
module tb_text_cell_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  text_cell_sequencer_if ifa ();
  text_cell_sequencer_if ifb ();

  text_cell_sequencer dut (.i_pix_clk(clk), .i_rst(rst), .bus(ifa));
  text_cell_sequencer #(.BLANK_ONLY(1'b1)) dut_blank (.i_pix_clk(clk), .i_rst(rst), .bus(ifb));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // All outputs of the main instance, packed as {ack0,err0,ack1,err1,wr,rd,busy,addr,data}.
  function automatic logic [31:0] outs_a();
    return {ifa.o_r0_ack, ifa.o_r0_err, ifa.o_r1_ack, ifa.o_r1_err,
            ifa.o_wr, ifa.o_rd, ifa.o_busy, ifa.o_addr, ifa.o_data};
  endfunction

  task automatic set_req(input bit who, input logic [6:0] col, input logic [5:0] row,
                         input logic [7:0] chr, input logic [7:0] fg, input logic [7:0] bg);
    if (!who) begin
      ifa.i_r0_col = col; ifa.i_r0_row = row; ifa.i_r0_char = chr;
      ifa.i_r0_fg = fg; ifa.i_r0_bg = bg; ifa.i_r0_req = 1'b1;
    end else begin
      ifa.i_r1_col = col; ifa.i_r1_row = row; ifa.i_r1_char = chr;
      ifa.i_r1_fg = fg; ifa.i_r1_bg = bg; ifa.i_r1_req = 1'b1;
    end
  endtask

  // Checks cycles 1..14 of a sequence whose request was sampled at the edge before cycle 1.
  task automatic run_seq(input string name, input bit who, input logic [6:0] col, input logic [5:0] row,
                         input logic [7:0] chr, input logic [7:0] fg, input logic [7:0] bg, input bit drop4);
    logic [6:0] ea;
    logic [7:0] ed;
    logic       ew;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      case ((k - 1) / 2)
        0: begin ea = 7'h44; ed = {1'b0, col}; end
        1: begin ea = 7'h45; ed = {2'b0, row}; end
        2: begin ea = 7'h46; ed = chr; end
        3: begin ea = 7'h48; ed = fg; end
        4: begin ea = 7'h49; ed = bg; end
        5: begin ea = 7'h4A; ed = 8'h00; end
        default: begin ea = 7'h00; ed = 8'h00; end
      endcase
      ew = (k <= 11) && (k % 2 == 1);
      chk($sformatf("%s c%0d outs", name, k), outs_a(),
          {(k == 13) && !who, 1'b0, (k == 13) && who, 1'b0, ew, 1'b0, 1'b1, ea, ed});
      if (k == 4 && drop4) begin
        if (!who) begin ifa.i_r0_req = 1'b0; ifa.i_r0_char = 8'hFF; end
        else      begin ifa.i_r1_req = 1'b0; ifa.i_r1_char = 8'hFF; end
      end
      if (k == 13) begin
        if (!who) ifa.i_r0_req = 1'b0; else ifa.i_r1_req = 1'b0;
      end
    end
    @(negedge clk);
    chk($sformatf("%s c14 idle", name), outs_a(), 32'h0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int  cnt;
    bit  seen;
    ifa.i_blank = 1'b0; ifb.i_blank = 1'b0;
    ifa.i_r0_req = 1'b0; ifa.i_r1_req = 1'b0; ifb.i_r0_req = 1'b0; ifb.i_r1_req = 1'b0;
    ifa.i_r0_col = '0; ifa.i_r0_row = '0; ifa.i_r0_char = '0; ifa.i_r0_fg = '0; ifa.i_r0_bg = '0;
    ifa.i_r1_col = '0; ifa.i_r1_row = '0; ifa.i_r1_char = '0; ifa.i_r1_fg = '0; ifa.i_r1_bg = '0;
    ifb.i_r0_col = '0; ifb.i_r0_row = '0; ifb.i_r0_char = '0; ifb.i_r0_fg = '0; ifb.i_r0_bg = '0;
    ifb.i_r1_col = '0; ifb.i_r1_row = '0; ifb.i_r1_char = '0; ifb.i_r1_fg = '0; ifb.i_r1_bg = '0;

    // Reset holds everything at zero even with a request pending.
    rst = 1'b1;
    ifa.i_r0_req = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset outs", outs_a(), 32'h0);
    chk("reset blank busy", {31'b0, ifb.o_busy}, 32'h0);
    chk("reset blank wr", {31'b0, ifb.o_wr}, 32'h0);
    ifa.i_r0_req = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    // A simultaneous pair right after reset goes r0 first, then r1 granted from IDLE cycle 14.
    set_req(0, 7'd6, 6'd3, 8'h62, 8'h03, 8'h07);
    set_req(1, 7'd12, 6'd20, 8'h41, 8'h0F, 8'h01);
    run_seq("pair1 r0", 0, 7'd6, 6'd3, 8'h62, 8'h03, 8'h07, 1'b0);
    run_seq("pair1 r1", 1, 7'd12, 6'd20, 8'h41, 8'h0F, 8'h01, 1'b0);

    // Second simultaneous pair: r1 was last, so r0 first again.
    set_req(0, 7'd0, 6'd0, 8'h20, 8'h05, 8'h00);
    set_req(1, 7'd1, 6'd1, 8'h21, 8'h06, 8'h02);
    run_seq("pair2 r0", 0, 7'd0, 6'd0, 8'h20, 8'h05, 8'h00, 1'b0);
    run_seq("pair2 r1", 1, 7'd1, 6'd1, 8'h21, 8'h06, 8'h02, 1'b0);

    // Column out of range: err and ack pulse together in cycle 1, with no write.
    set_req(1, 7'd80, 6'd5, 8'h30, 8'h01, 8'h02);
    @(negedge clk);
    chk("err col c1", outs_a(), {4'b0011, 1'b0, 1'b0, 1'b1, 7'h00, 8'h00});
    ifa.i_r1_req = 1'b0;
    @(negedge clk);
    chk("err col c2", outs_a(), 32'h0);

    // Row out of range on r0.
    set_req(0, 7'd3, 6'd40, 8'h30, 8'h01, 8'h02);
    @(negedge clk);
    chk("err row c1", outs_a(), {4'b1100, 1'b0, 1'b0, 1'b1, 7'h00, 8'h00});
    ifa.i_r0_req = 1'b0;
    @(negedge clk);
    chk("err row c2", outs_a(), 32'h0);

    // Corner cell at the limits is legal.
    set_req(1, 7'd79, 6'd39, 8'h7E, 8'hAA, 8'h55);
    run_seq("corner", 1, 7'd79, 6'd39, 8'h7E, 8'hAA, 8'h55, 1'b0);

    // Reset in cycle 6 aborts the sequence with no ack.
    set_req(0, 7'd10, 6'd5, 8'h33, 8'h04, 8'h08);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    ifa.i_r0_req = 1'b0;
    @(negedge clk);
    chk("rst mid c7", outs_a(), 32'h0);
    rst = 1'b0;
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (ifa.o_r0_ack || ifa.o_r1_ack || ifa.o_busy || ifa.o_wr) cnt++;
    end
    chk("rst mid quiet", cnt, 0);
    set_req(1, 7'd40, 6'd20, 8'h58, 8'h02, 8'h09);
    run_seq("after rst r1", 1, 7'd40, 6'd20, 8'h58, 8'h02, 8'h09, 1'b0);

    // Dropping req and changing char mid-sequence does not affect the latched cell.
    set_req(0, 7'd7, 6'd8, 8'h4D, 8'h0C, 8'h0D);
    run_seq("drop r0", 0, 7'd7, 6'd8, 8'h4D, 8'h0C, 8'h0D, 1'b1);

    // The blank-only instance waits in COL_W until blanking, then writes only while blank.
    ifb.i_r0_col = 7'd2; ifb.i_r0_row = 6'd1; ifb.i_r0_char = 8'h41;
    ifb.i_r0_fg = 8'h01; ifb.i_r0_bg = 8'h00; ifb.i_r0_req = 1'b1;
    cnt = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (ifb.o_wr !== 1'b0 || ifb.o_addr !== 7'h44 || ifb.o_busy !== 1'b1) cnt++;
    end
    chk("blank hold", cnt, 0);
    chk("blank hold addr", {25'b0, ifb.o_addr}, 32'h44);
    @(negedge clk);
    ifb.i_blank = 1'b1;
    #1;
    chk("blank first wr", {23'b0, ifb.o_wr, ifb.o_data}, {23'b0, 1'b1, 8'h02});
    @(negedge clk);
    chk("blank gap", {24'b0, ifb.o_wr, ifb.o_addr}, {24'b0, 1'b0, 7'h44});
    cnt = 0;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (ifb.o_wr) cnt++;
      if (ifb.o_r0_ack) seen = 1'b1;
    end
    ifb.i_r0_req = 1'b0;
    chk("blank ack seen", {31'b0, seen}, 32'h1);
    chk("blank wr count", cnt, 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
